// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by iterative_alu and its datapath.
// The DIV state is present only when ITERATIVE_ALU_DIV_EN is defined.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_SLT  = 4'd5,
      OP_MULU = 4'd6,
      OP_DIVU = 4'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
`ifdef ITERATIVE_ALU_DIV_EN
      S_DIV  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shared shift register datapath, one bit per step; shift-add multiply and
// (with ITERATIVE_ALU_DIV_EN) restoring divide. hi_nxt/lo_nxt show the result of the next step.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
`ifdef ITERATIVE_ALU_DIV_EN
   input  logic             div_sel,
`endif
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   // hi_q: partial product / remainder, lo_q: multiplier / dividend-quotient
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   mul_sum;
`ifdef ITERATIVE_ALU_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] rem_sub;
`endif

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ITERATIVE_ALU_DIV_EN
      shifted = {hi_q, lo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, b_q});
      // remainder stays below the divisor, so the subtraction fits in WIDTH bits
      rem_sub = shifted[WIDTH-1:0] - b_q;
      if (div_q) begin
         if (fits) begin
            hi_nxt = rem_sub;
            lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
`ifdef ITERATIVE_ALU_DIV_EN
         div_q <= 1'b0;
`endif
      end else if (load) begin
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
`ifdef ITERATIVE_ALU_DIV_EN
         div_q <= div_sel;
`endif
      end else if (step) begin
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
      end
   end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle simple ops plus iterative MULU/DIVU through muldiv_iter.
// Optional divider: define ITERATIVE_ALU_DIV_EN; otherwise opcode 7 is treated as illegal.
//
// state  | meaning
// IDLE   | ready, waiting for start
// MUL    | WIDTH shift-add steps
// DIV    | WIDTH restoring divide steps (ITERATIVE_ALU_DIV_EN only)
// DONE   | one-cycle done pulse, results valid
module iterative_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] out_r, out_nxt;
   logic [WIDTH-1:0] hi_r, hi_nxt;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] dp_hi_nxt, dp_lo_nxt;
   logic             load, step, last_iter;
`ifdef ITERATIVE_ALU_DIV_EN
   logic             div_sel;
   logic             dbz_r, dbz_nxt;
`endif

   assign last_iter = (cnt == CW'(WIDTH - 1));

   always_comb begin
      case (op)
         OP_PASS: alu_res = in1;
         OP_ADD:  alu_res = in1 + in2;
         OP_SUB:  alu_res = in1 - in2;
         OP_AND:  alu_res = in1 & in2;
         OP_OR:   alu_res = in1 | in2;
         OP_SLT:  alu_res = WIDTH'($signed(in1) < $signed(in2));
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out_r;
      hi_nxt    = hi_r;
      load      = 1'b0;
      step      = 1'b0;
`ifdef ITERATIVE_ALU_DIV_EN
      div_sel   = 1'b0;
      dbz_nxt   = dbz_r;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_nxt = '0;
               if (op == OP_MULU) begin
                  load      = 1'b1;
                  state_nxt = S_MUL;
`ifdef ITERATIVE_ALU_DIV_EN
               end else if (op == OP_DIVU) begin
                  if (in2 != '0) begin
                     load      = 1'b1;
                     div_sel   = 1'b1;
                     state_nxt = S_DIV;
                  end else begin
                     state_nxt = S_DONE;
                     out_nxt   = '1;
                     hi_nxt    = in1;
                     dbz_nxt   = 1'b1;
                  end
`endif
               end else begin
                  state_nxt = S_DONE;
                  out_nxt   = alu_res;
                  hi_nxt    = '0;
`ifdef ITERATIVE_ALU_DIV_EN
                  dbz_nxt   = 1'b0;
`endif
               end
            end
         end
`ifdef ITERATIVE_ALU_DIV_EN
         S_MUL, S_DIV: begin
`else
         S_MUL: begin
`endif
            step = 1'b1;
            if (last_iter) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
               out_nxt   = dp_lo_nxt;
               hi_nxt    = dp_hi_nxt;
`ifdef ITERATIVE_ALU_DIV_EN
               dbz_nxt   = 1'b0;
`endif
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         out_r <= '0;
         hi_r  <= '0;
`ifdef ITERATIVE_ALU_DIV_EN
         dbz_r <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out_r <= out_nxt;
         hi_r  <= hi_nxt;
`ifdef ITERATIVE_ALU_DIV_EN
         dbz_r <= dbz_nxt;
`endif
      end
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
`ifdef ITERATIVE_ALU_DIV_EN
      .div_sel (div_sel),
`endif
      .step    (step),
      .a       (in1),
      .b       (in2),
      .hi_nxt  (dp_hi_nxt),
      .lo_nxt  (dp_lo_nxt)
   );

   assign ready = (state == S_IDLE);
   assign done  = (state == S_DONE);
   assign out   = out_r;
   assign hi    = hi_r;
`ifdef ITERATIVE_ALU_DIV_EN
   assign div_by_zero = dbz_r;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: scoreboard bench for iterative_alu at WIDTH=32; expectations follow
// ITERATIVE_ALU_DIV_EN so the same bench serves both builds.
module tb_iterative_alu;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   op    = 4'd0;
   logic [W-1:0] in1   = '0;
   logic [W-1:0] in2   = '0;
   logic         ready, done, div_by_zero;
   logic [W-1:0] out, hi;

   typedef struct {
      logic [W-1:0] out;
      logic [W-1:0] hi;
      logic         dbz;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   iterative_alu #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .in1         (in1),
      .in2         (in2),
      .ready       (ready),
      .done        (done),
      .out         (out),
      .hi          (hi),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [63:0] p;
      e.out = '0;
      e.hi  = '0;
      e.dbz = 1'b0;
      e.cyc = 1;
      case (o)
         4'd0: e.out = a;
         4'd1: e.out = a + b;
         4'd2: e.out = a - b;
         4'd3: e.out = a & b;
         4'd4: e.out = a | b;
         4'd5: e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: begin
            p     = {32'd0, a} * {32'd0, b};
            e.out = p[31:0];
            e.hi  = p[63:32];
            e.cyc = W + 1;
         end
`ifdef ITERATIVE_ALU_DIV_EN
         4'd7: begin
            if (b == 0) begin
               e.out = '1;
               e.hi  = a;
               e.dbz = 1'b1;
            end else begin
               e.out = a / b;
               e.hi  = a % b;
               e.cyc = W + 1;
            end
         end
`endif
         default: ;
      endcase
      return e;
   endfunction

   // completion monitor: every done pulse must match the oldest outstanding expectation
   always @(posedge clock) begin
      exp_t e;
      cyc++;
      #1;
      if (done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("out", out, e.out);
            chk("hi", hi, e.hi);
            chk("dbz", div_by_zero, e.dbz);
            chk("latency", cyc, e.cyc);
         end
      end
   end

   task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t e;
      @(negedge clock);
      start = 1'b1;
      op    = o;
      in1   = a;
      in2   = b;
      if (push) begin
         e     = model(o, a, b);
         e.cyc = cyc + e.cyc;
         q.push_back(e);
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (q.size() != 0) begin
         chk("timeout_pending", q.size(), 0);
         q.delete();
      end
      @(negedge clock);
   endtask

   task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      send(o, a, b, 1'b1);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_bad;
      repeat (3) @(negedge clock);
      chk("rst_out", out, 0);
      chk("rst_hi", hi, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_ready", ready, 1);

      run(4'd1, 32'hFFFF_FFFF, 32'h1);
      run(4'd5, 32'hFFFF_FFFF, 32'h1);
      run(4'd5, 32'h1, 32'hFFFF_FFFF);
      run(4'd0, 32'hDEAD_BEEF, 32'h1234_5678);
      run(4'd2, 32'h0, 32'h1);
      run(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00);
      run(4'd4, 32'hF000_0001, 32'h0000_1100);
      run(4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
      run(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // multiply: ready must stay low for cycles 1..32
      send(4'd6, 32'hFFFF_FFFF, 32'h2, 1'b1);
      busy_bad = 0;
      for (int i = 0; i < W; i++) begin
         if (ready !== 1'b0) busy_bad++;
         @(negedge clock);
      end
      chk("mul_busy_ready", busy_bad, 0);
      drain();
      run(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(4'd6, 32'h0, 32'h1234_5678);

      run(4'd7, 32'd100, 32'd7);
      run(4'd7, 32'd5, 32'd0);
      run(4'd7, 32'hFFFF_FFFF, 32'd1);
      run(4'd7, 32'd3, 32'd10);

      // start while busy is ignored
      send(4'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      repeat (9) @(negedge clock);
      start = 1'b1;
      op    = 4'd1;
      in1   = 32'd3;
      in2   = 32'd4;
      @(negedge clock);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clock);

      // reset mid-multiply aborts with no done pulse
      send(4'd6, 32'hFFFF_FFFF, 32'h2, 1'b0);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      op    = 4'd1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      chk("abort_out", out, 0);
      chk("abort_hi", hi, 0);
      chk("abort_dbz", div_by_zero, 0);
      chk("abort_ready", ready, 1);
      repeat (40) @(negedge clock);
      chk("abort_quiet_ready", ready, 1);
      run(4'd1, 32'd1, 32'd1);

      for (int i = 0; i < 8; i++) begin
         run(4'($urandom_range(0, 15)), $urandom, (i == 3) ? 32'd0 : $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
